mem_access_unit: RTL and testbench

Memory-stage data-bus controller. It accepts one load or store per handshake from the pipeline and places store data and byte strobes on the correct 64-bit lanes. It drives the data-bus request until the bus returns data, then extracts and sign- or zero-extends load data and delivers a registered one-cycle response. It sits between the execute/memory pipeline register and the core's data-bus port, and it owns the byte-lane formatting for all data accesses.

---
 rtl/mem_access_unit_if.sv | 55 +++++
 rtl/mem_access_unit.sv | 154 +++++++++++++++
 tb/tb_mem_access_unit.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Size package and pipeline/data-bus interface for mem_access_unit.
// Ports: req_* (pipeline in), dbus_* (data bus), resp_* (completion out).
package mem_access_unit_pkg;
   typedef enum logic [1:0] {
      MSIZE1 = 2'd0,
      MSIZE2 = 2'd1,
      MSIZE4 = 2'd2,
      MSIZE8 = 2'd3
   } msize_t;
endpackage

interface mem_access_unit_if;
   import mem_access_unit_pkg::*;

   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   msize_t      req_msize;
   logic        req_unsigned;

   logic        dbus_valid;
   logic [63:0] dbus_addr;
   msize_t      dbus_size;
   logic [7:0]  dbus_strobe;
   logic [63:0] dbus_data;
   logic        dbus_addr_ok;
   logic        dbus_data_ok;
   logic [63:0] dbus_rdata;

   logic        resp_valid;
   logic [63:0] resp_data;
   logic        resp_misalign;

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      input  req_msize, req_unsigned,
      input  dbus_addr_ok, dbus_data_ok, dbus_rdata,
      output req_ready,
      output dbus_valid, dbus_addr, dbus_size,
      output dbus_strobe, dbus_data,
      output resp_valid, resp_data, resp_misalign
   );

   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      output req_msize, req_unsigned,
      output dbus_addr_ok, dbus_data_ok, dbus_rdata,
      input  req_ready,
      input  dbus_valid, dbus_addr, dbus_size,
      input  dbus_strobe, dbus_data,
      input  resp_valid, resp_data, resp_misalign
   );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage data-bus controller: lane-formats stores, extends loads.
// Ports: clk, reset (async active-low), bus (mem_access_unit_if.slave).
// Option: MEM_MISALIGN_CHECK_EN rejects misaligned accesses unissued.
module mem_access_unit
   import mem_access_unit_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   mem_access_unit_if.slave bus
);

   typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

   state_t      state;
   logic        lat_write;
   logic        lat_unsigned;
   logic        misalign;
   logic [7:0]  st_strobe;
   logic [63:0] st_data;
   logic [63:0] ld_data;

   // addr_ok is informational only; completion waits on data_ok
   logic unused_addr_ok;
   assign unused_addr_ok = bus.dbus_addr_ok;

   function automatic logic [7:0] fmt_strobe(
      msize_t sz, logic [2:0] lo);
      logic [7:0] s;
      s = 8'h00;
      unique case (sz)
         MSIZE1: s = 8'h01 << lo;
         MSIZE2: s = 8'h03 << {lo[2:1], 1'b0};
         MSIZE4: s = lo[2] ? 8'hf0 : 8'h0f;
         MSIZE8: s = 8'hff;
      endcase
      return s;
   endfunction

   function automatic logic [63:0] fmt_store(
      msize_t sz, logic [2:0] lo, logic [63:0] w);
      logic [63:0] d;
      d = '0;
      unique case (sz)
         MSIZE1: d = {56'd0, w[7:0]} << {lo, 3'b000};
         MSIZE2: d = {48'd0, w[15:0]} << {lo[2:1], 4'b0000};
         MSIZE4: d = {32'd0, w[31:0]} << {lo[2], 5'b00000};
         MSIZE8: d = w;
      endcase
      return d;
   endfunction

   function automatic logic [63:0] fmt_load(
      msize_t sz, logic [2:0] lo, logic uns, logic [63:0] r);
      logic [63:0] sh;
      logic [63:0] d;
      logic        sx;
      sh = '0;
      d  = '0;
      sx = ~uns;
      unique case (sz)
         MSIZE1: begin
            sh = r >> {lo, 3'b000};
            d  = {{56{sx & sh[7]}}, sh[7:0]};
         end
         MSIZE2: begin
            sh = r >> {lo[2:1], 4'b0000};
            d  = {{48{sx & sh[15]}}, sh[15:0]};
         end
         MSIZE4: begin
            sh = r >> {lo[2], 5'b00000};
            d  = {{32{sx & sh[31]}}, sh[31:0]};
         end
         MSIZE8: d = r;
      endcase
      return d;
   endfunction

`ifdef MEM_MISALIGN_CHECK_EN
   always_comb begin
      misalign = 1'b0;
      unique case (bus.req_msize)
         MSIZE1: misalign = 1'b0;
         MSIZE2: misalign = bus.req_addr[0];
         MSIZE4: misalign = |bus.req_addr[1:0];
         MSIZE8: misalign = |bus.req_addr[2:0];
      endcase
   end
`else
   assign misalign = 1'b0;
`endif

   assign st_strobe = fmt_strobe(bus.req_msize, bus.req_addr[2:0]);
   assign st_data   = fmt_store(bus.req_msize, bus.req_addr[2:0],
                                bus.req_wdata);
   // Lane selection for loads uses the latched bus address/size
   assign ld_data   = fmt_load(bus.dbus_size, bus.dbus_addr[2:0],
                               lat_unsigned, bus.dbus_rdata);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state             <= IDLE;
         lat_write         <= 1'b0;
         lat_unsigned      <= 1'b0;
         bus.req_ready     <= 1'b1;
         bus.dbus_valid    <= 1'b0;
         bus.dbus_addr     <= '0;
         bus.dbus_size     <= MSIZE1;
         bus.dbus_strobe   <= '0;
         bus.dbus_data     <= '0;
         bus.resp_valid    <= 1'b0;
         bus.resp_data     <= '0;
         bus.resp_misalign <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  lat_write     <= bus.req_write;
                  lat_unsigned  <= bus.req_unsigned;
                  bus.dbus_addr <= bus.req_addr;
                  bus.dbus_size <= bus.req_msize;
                  bus.req_ready <= 1'b0;
                  if (misalign) begin
                     state             <= DONE;
                     bus.resp_valid    <= 1'b1;
                     bus.resp_data     <= '0;
                     bus.resp_misalign <= 1'b1;
                  end else begin
                     state           <= BUS;
                     bus.dbus_valid  <= 1'b1;
                     bus.dbus_strobe <= bus.req_write ? st_strobe : 8'h00;
                     bus.dbus_data   <= bus.req_write ? st_data : 64'd0;
                  end
               end
            end
            BUS: begin
               if (bus.dbus_data_ok) begin
                  state             <= DONE;
                  bus.dbus_valid    <= 1'b0;
                  bus.resp_valid    <= 1'b1;
                  bus.resp_data     <= lat_write ? 64'd0 : ld_data;
                  bus.resp_misalign <= 1'b0;
               end
            end
            DONE: begin
               state          <= IDLE;
               bus.resp_valid <= 1'b0;
               bus.req_ready  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte-level reference model.
// Checks bus/response outputs every cycle plus literal expectations.
module tb_mem_access_unit;
   import mem_access_unit_pkg::*;

   logic clk;
   logic reset;
   int   tests;
   int   fails;

   mem_access_unit_if bus();

   mem_access_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // current expectations used by the compare process
   logic [7:0]  exp_strb;
   logic [63:0] exp_bdata;
   logic [63:0] exp_addr;
   logic [1:0]  exp_size;
   logic [63:0] exp_rsp;
   logic        exp_mis;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // byte-lane reference: naturally aligned field inside the 8-byte word
   task automatic model(input bit wr, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [63:0] rdata,
                        input logic [1:0] sz, input bit uns,
                        output logic [7:0] strb, output logic [63:0] data,
                        output logic [63:0] rsp, output logic mis);
      int n, a, base;
      logic [63:0] v;
      n    = 1 << sz;
      a    = int'(addr[2:0]);
      base = (a / n) * n;
      strb = '0;
      data = '0;
      rsp  = '0;
`ifdef MEM_MISALIGN_CHECK_EN
      mis = (a % n) != 0;
`else
      mis = 1'b0;
`endif
      if (wr) begin
         for (int i = 0; i < n; i++) begin
            strb[base + i] = 1'b1;
            data[8*(base + i) +: 8] = wdata[8*i +: 8];
         end
      end else begin
         v = '0;
         for (int i = 0; i < n; i++)
            v[8*i +: 8] = rdata[8*(base + i) +: 8];
         if (!uns && n < 8 && v[8*n - 1])
            for (int j = 8*n; j < 64; j++) v[j] = 1'b1;
         rsp = v;
      end
      if (mis) begin
         rsp  = '0;
         strb = '0;
         data = '0;
      end
   endtask

   task automatic set_exp(input bit wr, input logic [63:0] addr,
                          input logic [63:0] wdata,
                          input logic [63:0] rdata,
                          input logic [1:0] sz, input bit uns,
                          input bit do_bus, input bit do_rsp);
      logic [7:0]  s;
      logic [63:0] d, r;
      logic        m;
      model(wr, addr, wdata, rdata, sz, uns, s, d, r, m);
      if (do_bus) begin
         exp_strb  = s;
         exp_bdata = d;
         exp_addr  = addr;
         exp_size  = sz;
      end
      if (do_rsp) begin
         exp_rsp = r;
         exp_mis = m;
      end
   endtask

   always @(negedge clk) begin
      if (reset) begin
         chk("ready_only_idle", {63'd0, bus.req_ready},
             {63'd0, !(bus.dbus_valid || bus.resp_valid)});
         if (bus.dbus_valid) begin
            chk("bus_strobe", {56'd0, bus.dbus_strobe}, {56'd0, exp_strb});
            chk("bus_data", bus.dbus_data, exp_bdata);
            chk("bus_addr", bus.dbus_addr, exp_addr);
            chk("bus_size", {62'd0, bus.dbus_size}, {62'd0, exp_size});
         end
         if (bus.resp_valid) begin
            chk("resp_data", bus.resp_data, exp_rsp);
            chk("resp_mis", {63'd0, bus.resp_misalign}, {63'd0, exp_mis});
         end
      end
   end

   logic [7:0]  obs_strb;
   logic [63:0] obs_data;

   task automatic do_access(input bit wr, input logic [63:0] addr,
                            input logic [63:0] wdata,
                            input logic [63:0] rdata,
                            input logic [1:0] sz, input bit uns,
                            input int dly);
      int cyc;
      set_exp(wr, addr, wdata, rdata, sz, uns, 1'b1, 1'b1);
      @(negedge clk);
      cyc = 0;
      while (!bus.req_ready && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 20) chk("ready_timeout", 64'd0, 64'd1);
      bus.req_write    = wr;
      bus.req_addr     = addr;
      bus.req_wdata    = wdata;
      bus.req_msize    = msize_t'(sz);
      bus.req_unsigned = uns;
      bus.dbus_rdata   = rdata;
      bus.req_valid    = 1'b1;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      obs_strb = bus.dbus_strobe;
      obs_data = bus.dbus_data;
      if (exp_mis) begin
         chk("mis_no_issue", {63'd0, bus.dbus_valid}, 64'd0);
         chk("mis_resp_at1", {63'd0, bus.resp_valid}, 64'd1);
      end else begin
         chk("issue_at1", {63'd0, bus.dbus_valid}, 64'd1);
         for (int c = 0; c < dly; c++) begin
            @(posedge clk);
            #1;
            chk("bus_held", {63'd0, bus.dbus_valid}, 64'd1);
            chk("no_early_resp", {63'd0, bus.resp_valid}, 64'd0);
         end
         bus.dbus_data_ok = 1'b1;
         @(posedge clk);
         #1;
         bus.dbus_data_ok = 1'b0;
         chk("resp_after_ok", {63'd0, bus.resp_valid}, 64'd1);
         chk("bus_dropped", {63'd0, bus.dbus_valid}, 64'd0);
      end
      @(posedge clk);
      #1;
      chk("resp_one_cycle", {63'd0, bus.resp_valid}, 64'd0);
      chk("ready_again", {63'd0, bus.req_ready}, 64'd1);
      chk("resp_hold", bus.resp_data, exp_rsp);
   endtask

   logic        t_wr   [6];
   logic [63:0] t_addr [6];
   logic [63:0] t_wd   [6];
   logic [63:0] t_rd   [6];
   logic [1:0]  t_sz   [6];
   logic        t_uns  [6];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      tests = 0;
      fails = 0;
      exp_strb = '0; exp_bdata = '0; exp_addr = '0;
      exp_size = '0; exp_rsp = '0; exp_mis = 1'b0;
      bus.req_valid    = 1'b0;
      bus.req_write    = 1'b0;
      bus.req_addr     = '0;
      bus.req_wdata    = '0;
      bus.req_msize    = MSIZE1;
      bus.req_unsigned = 1'b0;
      bus.dbus_addr_ok = 1'b0;
      bus.dbus_data_ok = 1'b0;
      bus.dbus_rdata   = '0;
      reset = 1'b1;
      #3 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_dbus_valid", {63'd0, bus.dbus_valid}, 64'd0);
      chk("rst_strobe", {56'd0, bus.dbus_strobe}, 64'd0);
      chk("rst_data", bus.dbus_data, 64'd0);
      chk("rst_addr", bus.dbus_addr, 64'd0);
      chk("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
      chk("rst_resp_data", bus.resp_data, 64'd0);
      chk("rst_resp_mis", {63'd0, bus.resp_misalign}, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_ready", {63'd0, bus.req_ready}, 64'd1);

      // signed byte load, data_ok two cycles into BUS
      do_access(1'b0, 64'h1003, 64'h0, 64'h00000000_80000000,
                2'd0, 1'b0, 2);
      chk("lit_load_strobe", {56'd0, obs_strb}, 64'd0);
      chk("lit_sbyte", bus.resp_data, 64'hFFFFFFFF_FFFFFF80);

      // halfword store
      do_access(1'b1, 64'h2006, 64'hABCD, 64'h0, 2'd1, 1'b0, 2);
      chk("lit_hstore_strobe", {56'd0, obs_strb}, 64'h00c0);
      chk("lit_hstore_data", obs_data, 64'hABCD0000_00000000);
      chk("lit_store_resp", bus.resp_data, 64'd0);

      // unsigned word load, data_ok in first BUS cycle
      do_access(1'b0, 64'h3004, 64'h0, 64'h87654321_00000000,
                2'd2, 1'b1, 0);
      chk("lit_uword", bus.resp_data, 64'h00000000_87654321);

      // misaligned word store
      do_access(1'b1, 64'h4002, 64'h11223344, 64'h0, 2'd2, 1'b0, 1);
`ifdef MEM_MISALIGN_CHECK_EN
      chk("lit_mis_flag", {63'd0, bus.resp_misalign}, 64'd1);
      chk("lit_mis_data", bus.resp_data, 64'd0);
`else
      chk("lit_mis_strobe", {56'd0, obs_strb}, 64'h000f);
      chk("lit_mis_data", obs_data, 64'h00000000_11223344);
      chk("lit_mis_flag", {63'd0, bus.resp_misalign}, 64'd0);
`endif

      // mixed table
      t_wr[0] = 0; t_addr[0] = 64'h7002; t_sz[0] = 1; t_uns[0] = 0;
      t_rd[0] = 64'h00000000_80010000; t_wd[0] = 0;
      t_wr[1] = 0; t_addr[1] = 64'h7007; t_sz[1] = 0; t_uns[1] = 1;
      t_rd[1] = 64'hF0000000_00000000; t_wd[1] = 0;
      t_wr[2] = 1; t_addr[2] = 64'h7008; t_sz[2] = 3; t_uns[2] = 0;
      t_rd[2] = 0; t_wd[2] = 64'h01234567_89ABCDEF;
      t_wr[3] = 0; t_addr[3] = 64'h7000; t_sz[3] = 2; t_uns[3] = 0;
      t_rd[3] = 64'hFFFF0000_7FFFFFFF; t_wd[3] = 0;
      t_wr[4] = 1; t_addr[4] = 64'h7001; t_sz[4] = 0; t_uns[4] = 0;
      t_rd[4] = 0; t_wd[4] = 64'hFFEE;
      t_wr[5] = 0; t_addr[5] = 64'h7010; t_sz[5] = 3; t_uns[5] = 0;
      t_rd[5] = 64'h80000000_00000001; t_wd[5] = 0;
      for (int i = 0; i < 6; i++)
         do_access(t_wr[i], t_addr[i], t_wd[i], t_rd[i],
                   t_sz[i], t_uns[i], i % 3);
      chk("lit_tab_last", bus.resp_data, 64'h80000000_00000001);

      // reset in the middle of a bus transaction
      set_exp(1'b0, 64'h5000, 64'h0, 64'h0, 2'd3, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      bus.req_write = 1'b0;
      bus.req_addr  = 64'h5000;
      bus.req_msize = MSIZE8;
      bus.req_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      chk("mid_issue", {63'd0, bus.dbus_valid}, 64'd1);
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_async_valid", {63'd0, bus.dbus_valid}, 64'd0);
      chk("mid_async_addr", bus.dbus_addr, 64'd0);
      chk("mid_no_resp", {63'd0, bus.resp_valid}, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         chk("post_rst_ready", {63'd0, bus.req_ready}, 64'd1);
         chk("post_rst_noresp", {63'd0, bus.resp_valid}, 64'd0);
      end

      // back-to-back with req_valid and both bus acks held high
      set_exp(1'b0, 64'h6000, 64'h0, 64'hCAFEF00D_12345678,
              2'd3, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      bus.req_write    = 1'b0;
      bus.req_addr     = 64'h6000;
      bus.req_msize    = MSIZE8;
      bus.req_unsigned = 1'b0;
      bus.dbus_rdata   = 64'hCAFEF00D_12345678;
      bus.dbus_addr_ok = 1'b1;
      bus.dbus_data_ok = 1'b1;
      bus.req_valid    = 1'b1;
      @(posedge clk);
      #1;
      chk("b2b_a_issue", {63'd0, bus.dbus_valid}, 64'd1);
      chk("b2b_a_addr", bus.dbus_addr, 64'h6000);
      bus.req_write = 1'b1;
      bus.req_addr  = 64'h6005;
      bus.req_wdata = 64'h5A;
      bus.req_msize = MSIZE1;
      @(posedge clk);
      #1;
      chk("b2b_done_resp", {63'd0, bus.resp_valid}, 64'd1);
      chk("b2b_done_nobus", {63'd0, bus.dbus_valid}, 64'd0);
      chk("b2b_done_busy", {63'd0, bus.req_ready}, 64'd0);
      chk("lit_b2b_a_resp", bus.resp_data, 64'hCAFEF00D_12345678);
      set_exp(1'b1, 64'h6005, 64'h5A, 64'h0, 2'd0, 1'b0, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      chk("b2b_idle_nobus", {63'd0, bus.dbus_valid}, 64'd0);
      chk("b2b_idle_ready", {63'd0, bus.req_ready}, 64'd1);
      set_exp(1'b1, 64'h6005, 64'h5A, 64'h0, 2'd0, 1'b0, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      chk("b2b_b_issue", {63'd0, bus.dbus_valid}, 64'd1);
      chk("lit_b2b_b_strobe", {56'd0, bus.dbus_strobe}, 64'h0020);
      chk("lit_b2b_b_data", bus.dbus_data, 64'h00005A00_00000000);
      @(posedge clk);
      #1;
      bus.dbus_data_ok = 1'b0;
      bus.dbus_addr_ok = 1'b0;
      chk("b2b_b_resp", {63'd0, bus.resp_valid}, 64'd1);
      chk("lit_b2b_b_rdata", bus.resp_data, 64'd0);
      @(posedge clk);
      #1;
      chk("b2b_b_pulse", {63'd0, bus.resp_valid}, 64'd0);

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
